// File: rtl/bch_error_correct_if.sv
// Stream bundle between the Chien search stage, the raw data source and the
// downstream consumer of the corrected bit stream.
interface bch_error_correct_if #(
   parameter int M  = 4,
   parameter int T  = 3,
   parameter int DW = 5
) ();
   localparam int DGW = (T > 0) ? $clog2(T + 1) : 1;

   logic                 data_in;
   logic                 data_in_valid;
   logic                 data_in_ready;
   logic [(T+1)*M-1:0]   chien;
   logic                 chien_valid;
   logic                 chien_first;
   logic                 chien_last;
   logic                 chien_accepted;
   logic                 err_feedback;
   logic [DGW-1:0]       degree;
   logic                 out_data;
   logic                 out_valid;
   logic                 out_first;
   logic                 out_last;
   logic                 out_ready;
   logic [DW-1:0]        err_count;
   logic                 done;
   logic                 fail;

   modport slave (
      input  data_in, data_in_valid, chien, chien_valid, chien_first, chien_last,
             degree, out_ready,
      output data_in_ready, chien_accepted, err_feedback, out_data, out_valid,
             out_first, out_last, err_count, done, fail
   );

   modport master (
      output data_in, data_in_valid, chien, chien_valid, chien_first, chien_last,
             degree, out_ready,
      input  data_in_ready, chien_accepted, err_feedback, out_data, out_valid,
             out_first, out_last, err_count, done, fail
   );
endinterface

// File: rtl/bch_error_correct.sv
// BCH correction stage: buffers raw bits, flips those at Chien roots, counts
// corrections per frame and flags frames whose count disagrees with the degree.
module bch_error_correct #(
   parameter int M          = 4,
   parameter int T          = 3,
   parameter int DATA_BITS  = 11,
   parameter int FIFO_DEPTH = 16,
   parameter int DW         = 5
) (
   input  logic               clk,
   input  logic               reset,
   bch_error_correct_if.slave bus
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int DGW = (T > 0) ? $clog2(T + 1) : 1;
   localparam logic [AW:0]   PTR_ONE = 1;
   localparam logic [DW-1:0] CNT_ONE = 1;
   localparam logic [DW-1:0] CNT_MAX = '1;

   generate
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("FIFO_DEPTH must be a power of two, at least 2");
      end
      if (DW < DGW + 1) begin : g_bad_dw
         $error("DW too narrow for the correction capability");
      end
      if (DATA_BITS < 1) begin : g_bad_bits
         $error("DATA_BITS must be positive");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t          state_reg;
   logic            fifo_mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
   logic            out_data_reg, out_valid_reg, out_first_reg, out_last_reg;
   logic [DW-1:0]   err_count_reg;
   logic [DGW-1:0]  degree_reg;
   logic            done_reg, fail_reg;

   logic            fifo_empty, fifo_full, fifo_head, wr_en;
   logic [M-1:0]    chien_sum;
   logic            hit, accept;

   always_comb begin
      chien_sum = '0;
      for (int i = 0; i <= T; i++) chien_sum = chien_sum ^ bus.chien[i*M +: M];
   end

   // Extra pointer MSB tells a full buffer from an empty one.
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];
   assign wr_en      = bus.data_in_valid && !fifo_full;

   assign hit    = (chien_sum == '0) && bus.chien_valid;
   assign accept = bus.chien_valid && !fifo_empty && (!out_valid_reg || bus.out_ready) &&
                   (state_reg != FLUSH);

   assign bus.data_in_ready  = !fifo_full;
   assign bus.chien_accepted = accept;
   assign bus.err_feedback   = hit && accept;
   assign bus.out_data       = out_data_reg;
   assign bus.out_valid      = out_valid_reg;
   assign bus.out_first      = out_first_reg;
   assign bus.out_last       = out_last_reg;
   assign bus.err_count      = err_count_reg;
   assign bus.done           = done_reg;
   assign bus.fail           = fail_reg;

   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         out_data_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_first_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         err_count_reg <= '0;
         degree_reg    <= '0;
         done_reg      <= 1'b0;
         fail_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (wr_en)  wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (accept) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;

         if (accept) begin
            out_data_reg  <= fifo_head ^ hit;
            out_first_reg <= bus.chien_first;
            out_last_reg  <= bus.chien_last;
            out_valid_reg <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
         end

         // An accepted first position always (re)starts a frame, aborting any open one.
         if (accept && bus.chien_first) begin
            err_count_reg <= {{(DW-1){1'b0}}, hit};
            degree_reg    <= bus.degree;
            fail_reg      <= 1'b0;
            state_reg     <= bus.chien_last ? FLUSH : RUN;
         end else begin
            case (state_reg)
               RUN: begin
                  if (accept) begin
                     if (hit && (err_count_reg != CNT_MAX))
                        err_count_reg <= err_count_reg + CNT_ONE;
                     if (bus.chien_last) state_reg <= FLUSH;
                  end
               end
               FLUSH: begin
                  if (out_valid_reg && bus.out_ready && out_last_reg) begin
                     done_reg  <= 1'b1;
                     fail_reg  <= (err_count_reg != DW'(degree_reg));
                     state_reg <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
